parser_hdr_extract: RTL and testbench

- Ingress counterpart of the deparser: accepts the AXI-Stream packet, forwards every beat unchanged into the packet FIFO, and captures the first 8 beats plus metadata into one PHV written to the PHV FIFO.
- The deparser later reads both FIFOs.
- Exactly one PHV is produced per packet, in packet order.

---
 rtl/parser_hdr_extract_if.sv | 46 ++++
 rtl/parser_hdr_extract.sv | 85 ++++++++
 tb/tb_parser_hdr_extract.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parser_hdr_extract_if.sv
// Ingress AXI-Stream, packet-FIFO write side, PHV-FIFO write side and packet counter of the parser.
interface parser_hdr_extract_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PKT_VEC_WIDTH    = 4*64*8+256
);
  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic                           s_axis_tvalid;
  logic                           s_axis_tlast;
  logic                           s_axis_tready;

  logic [C_AXIS_DATA_WIDTH-1:0]   pkt_fifo_tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] pkt_fifo_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  pkt_fifo_tuser;
  logic                           pkt_fifo_tlast;
  logic                           pkt_fifo_wr_en;
  logic                           pkt_fifo_full;

  logic [C_PKT_VEC_WIDTH-1:0]     phv_fifo_in;
  logic                           phv_fifo_wr_en;
  logic                           phv_fifo_full;

  logic [31:0]                    pkt_count;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_wr_en,
    input  pkt_fifo_full,
    output phv_fifo_in, phv_fifo_wr_en,
    input  phv_fifo_full,
    output pkt_count
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  pkt_fifo_tdata, pkt_fifo_tkeep, pkt_fifo_tuser, pkt_fifo_tlast, pkt_fifo_wr_en,
    output pkt_fifo_full,
    input  phv_fifo_in, phv_fifo_wr_en,
    output phv_fifo_full,
    input  pkt_count
  );
endinterface

// File: rtl/parser_hdr_extract.sv
// Forwards beats to the packet FIFO (zero latency, stalls on pkt_fifo_full) and builds one PHV per
// packet from the first header beats plus metadata; the PHV is written the cycle after tlast, held while phv_fifo_full.
module parser_hdr_extract #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_PKT_VEC_WIDTH    = 4*64*8+256,
  parameter int C_HDR_BEATS        = 8,
  parameter int C_VLANID_WIDTH     = 12
) (
  input logic                 axis_clk,
  input logic                 areset,
  parser_hdr_extract_if.slave bus
);
  localparam int C_META_WIDTH = C_PKT_VEC_WIDTH - C_HDR_BEATS*C_AXIS_DATA_WIDTH;
  localparam int C_VID_LO     = C_AXIS_TUSER_WIDTH;
  localparam int C_CNT_LO     = C_VID_LO + C_VLANID_WIDTH;

  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_BODY  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  logic [1:0]                 state;
  logic [7:0]                 beat_cnt;
  logic [7:0]                 beat_nxt;
  logic [C_PKT_VEC_WIDTH-1:0] phv;
  logic [31:0]                pkt_count_q;
  logic [C_META_WIDTH-1:0]    meta_first;
  logic                       accept;
  logic                       emit;

  assign bus.s_axis_tready = !areset && !bus.pkt_fifo_full && (state != ST_EMIT);
  assign accept            = bus.s_axis_tvalid && bus.s_axis_tready;
  assign emit              = !areset && (state == ST_EMIT) && !bus.phv_fifo_full;
  assign beat_nxt          = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;

  assign bus.pkt_fifo_tdata = bus.s_axis_tdata;
  assign bus.pkt_fifo_tkeep = bus.s_axis_tkeep;
  assign bus.pkt_fifo_tuser = bus.s_axis_tuser;
  assign bus.pkt_fifo_tlast = bus.s_axis_tlast;
  assign bus.pkt_fifo_wr_en = accept;

  assign bus.phv_fifo_in    = phv;
  assign bus.phv_fifo_wr_en = emit;
  assign bus.pkt_count      = pkt_count_q;

  // VID is taken from bytes 14-15 regardless of EtherType; the count field is filled at tlast.
  always_comb begin
    meta_first                               = '0;
    meta_first[C_VID_LO-1:0]                 = bus.s_axis_tuser;
    meta_first[C_VID_LO +: C_VLANID_WIDTH]   = {bus.s_axis_tdata[115:112], bus.s_axis_tdata[127:120]};
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state       <= ST_FIRST;
      beat_cnt    <= 8'd0;
      phv         <= '0;
      pkt_count_q <= 32'd0;
    end else if (accept) begin
      beat_cnt <= beat_nxt;
      // The first beat clears every other slot so a short packet never carries stale headers.
      for (int s = 0; s < C_HDR_BEATS; s++) begin
        if (beat_cnt == 8'(s))
          phv[C_META_WIDTH + s*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] <= bus.s_axis_tdata;
        else if (state == ST_FIRST)
          phv[C_META_WIDTH + s*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] <= '0;
      end
      if (state == ST_FIRST)
        phv[C_META_WIDTH-1:0] <= meta_first;
      if (bus.s_axis_tlast) begin
        state              <= ST_EMIT;
        phv[C_CNT_LO +: 8] <= beat_nxt;
      end else if (state == ST_FIRST) begin
        state <= ST_HDR;
      end else if (state == ST_HDR && beat_nxt == 8'(C_HDR_BEATS)) begin
        state <= ST_BODY;
      end
    end else if (emit) begin
      pkt_count_q <= pkt_count_q + 32'd1;
      beat_cnt    <= 8'd0;
      state       <= ST_FIRST;
    end
  end
endmodule

// File: tb/tb_parser_hdr_extract.sv
// Bench for parser_hdr_extract: scoreboarded beat and PHV streams across short, long, stalled and reset packets.
module tb_parser_hdr_extract;
  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  keep;
    logic [255:0] data;
  } beat_t;

  logic axis_clk = 1'b0;
  logic areset;
  always #5 axis_clk = ~axis_clk;

  parser_hdr_extract_if bus();
  parser_hdr_extract dut (.axis_clk(axis_clk), .areset(areset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int samp_cyc = 0;
  int last_acc_cyc = 0;
  int mirror_bad = 0;
  bit rdy_s, pktwr_s, phvwr_s, acc_s;
  bit toggle_full = 1'b0;
  logic [31:0] exp_count = 32'd0;

  beat_t         exp_beat_q[$];
  beat_t         obs_beat_q[$];
  logic [2303:0] exp_phv_q[$];
  logic [2303:0] obs_phv_q[$];
  int            obs_phv_cyc[$];
  logic [255:0]  mdl_data[$];

  function automatic logic [2303:0] model_phv(input int n, input logic [127:0] u);
    logic [2303:0] p  = '0;
    logic [255:0]  d0 = mdl_data[0];
    p[127:0]   = u;
    p[139:128] = {d0[115:112], d0[127:120]};
    p[147:140] = (n > 255) ? 8'hFF : 8'(n);
    for (int i = 0; i < 8 && i < n; i++) p[256 + i*256 +: 256] = mdl_data[i];
    return p;
  endfunction

  task automatic clk_step();
    @(negedge axis_clk);
    samp_cyc = cyc;
    rdy_s    = bus.s_axis_tready;
    pktwr_s  = bus.pkt_fifo_wr_en;
    phvwr_s  = bus.phv_fifo_wr_en;
    acc_s    = bus.s_axis_tvalid && bus.s_axis_tready;
    if (pktwr_s)
      obs_beat_q.push_back(beat_t'({bus.pkt_fifo_tlast, bus.pkt_fifo_tuser, bus.pkt_fifo_tkeep, bus.pkt_fifo_tdata}));
    if (phvwr_s) begin
      obs_phv_q.push_back(bus.phv_fifo_in);
      obs_phv_cyc.push_back(cyc);
    end
    if (toggle_full && bus.s_axis_tvalid && !areset && rdy_s !== !bus.pkt_fifo_full) mirror_bad++;
    @(posedge axis_clk);
    #1;
    cyc++;
    if (toggle_full) bus.pkt_fifo_full = ~bus.pkt_fifo_full;
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u, input logic l);
    bit done = 1'b0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tuser  = u;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    exp_beat_q.push_back(beat_t'({l, u, k, d}));
    for (int t = 0; t < 50 && !done; t++) begin
      clk_step();
      done = acc_s;
    end
    if (done) last_acc_cyc = samp_cyc;
    else begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: beat not accepted within 50 cycles, required acceptance");
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit cnt_pat, input logic [255:0] d0, input logic [127:0] u);
    logic [255:0] d;
    mdl_data.delete();
    for (int i = 0; i < n; i++) begin
      d = cnt_pat ? 256'(i + 1) : ((i == 0) ? d0 : {8{$urandom}});
      mdl_data.push_back(d);
    end
    exp_phv_q.push_back(model_phv(n, u));
    exp_count++;
    for (int i = 0; i < n; i++)
      send_beat(mdl_data[i], (i == n-1) ? 32'($urandom) : 32'hFFFF_FFFF,
                (i == 0) ? u : {4{$urandom}}, (i == n-1));
  endtask

  task automatic wait_phv(input int n);
    int t = 0;
    while (obs_phv_q.size() < n && t < 40) begin
      clk_step();
      t++;
    end
    checks++;
    if (obs_phv_q.size() < n) begin
      errors++;
      $display("FAIL phv_timeout: got %0d PHV writes, required %0d", obs_phv_q.size(), n);
    end
  endtask

  task automatic test_reset();
    beat_t ob;
    areset = 1'b1;
    bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = {8{32'hDEAD_BEEF}};
    clk_step(); clk_step();
    checks++; if (rdy_s !== 1'b0)   begin errors++; $display("FAIL reset_tready got %b exp 0", rdy_s); end
    checks++; if (pktwr_s !== 1'b0) begin errors++; $display("FAIL reset_pkt_wr got %b exp 0", pktwr_s); end
    checks++; if (phvwr_s !== 1'b0) begin errors++; $display("FAIL reset_phv_wr got %b exp 0", phvwr_s); end
    checks++; if (bus.pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", bus.pkt_count); end
    areset = 1'b0; bus.s_axis_tvalid = 1'b0;
    clk_step();
    checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL idle_tready got %b exp 1", rdy_s); end
    checks++; if (bus.phv_fifo_in !== '0) begin errors++; $display("FAIL reset_phv_reg not zero"); end
    while (obs_beat_q.size() > 0) ob = obs_beat_q.pop_front();
  endtask

  task automatic test_single_beat();
    logic [255:0] d = {8{$urandom}};
    logic [2303:0] ep, op;
    beat_t eb, ob;
    d[119:112] = 8'h81; d[127:120] = 8'h23;
    send_pkt(1, 1'b0, d, 128'hAB);
    wait_phv(1);
    checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL single_emit_tready got %b exp 0", rdy_s); end
    checks++;
    if (obs_phv_cyc[0] != last_acc_cyc + 1) begin
      errors++; $display("FAIL single_phv_latency got cycle %0d exp %0d", obs_phv_cyc[0], last_acc_cyc + 1);
    end
    checks++; if (obs_phv_q[0][139:128] !== 12'h123) begin errors++; $display("FAIL single_vid got %h exp 123", obs_phv_q[0][139:128]); end
    checks++; if (obs_beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL single_beats got %0d exp %0d", obs_beat_q.size(), exp_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL single_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL single_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    checks++; if (bus.pkt_count !== exp_count) begin errors++; $display("FAIL single_pkt_count got %0d exp %0d", bus.pkt_count, exp_count); end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  task automatic test_long_pkt();
    logic [2303:0] ep, op;
    beat_t eb, ob;
    send_pkt(10, 1'b1, '0, {4{$urandom}});
    wait_phv(1);
    checks++;
    if (obs_phv_cyc[0] != last_acc_cyc + 1) begin
      errors++; $display("FAIL long_phv_latency got cycle %0d exp %0d", obs_phv_cyc[0], last_acc_cyc + 1);
    end
    clk_step(); clk_step(); clk_step();
    checks++; if (obs_phv_q.size() != 1) begin errors++; $display("FAIL long_phv_writes got %0d exp 1", obs_phv_q.size()); end
    checks++; if (obs_phv_q[0][147:140] !== 8'd10) begin errors++; $display("FAIL long_beat_count got %0d exp 10", obs_phv_q[0][147:140]); end
    checks++; if (obs_beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL long_beats got %0d exp %0d", obs_beat_q.size(), exp_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL long_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL long_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  task automatic test_phv_full();
    logic [2303:0] ep, op;
    beat_t eb, ob;
    int wr_cyc;
    bus.phv_fifo_full = 1'b1;
    send_pkt(3, 1'b0, {8{$urandom}}, {4{$urandom}});
    for (int i = 0; i < 5; i++) begin
      clk_step();
      checks++; if (rdy_s !== 1'b0 || phvwr_s !== 1'b0) begin errors++; $display("FAIL stall_cycle %0d tready %b phv_wr %b exp 0 0", i, rdy_s, phvwr_s); end
    end
    bus.phv_fifo_full = 1'b0;
    clk_step();
    checks++; if (phvwr_s !== 1'b1 || rdy_s !== 1'b0) begin errors++; $display("FAIL release_cycle phv_wr %b tready %b exp 1 0", phvwr_s, rdy_s); end
    wr_cyc = samp_cyc;
    send_pkt(1, 1'b0, {8{$urandom}}, {4{$urandom}});
    checks++; if (last_acc_cyc != wr_cyc + 1) begin errors++; $display("FAIL next_accept cycle got %0d exp %0d", last_acc_cyc, wr_cyc + 1); end
    wait_phv(2);
    checks++; if (obs_beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL stall_beats got %0d exp %0d", obs_beat_q.size(), exp_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL stall_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL stall_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  task automatic test_pkt_backpressure();
    logic [2303:0] ep, op;
    beat_t eb, ob;
    mirror_bad  = 0;
    toggle_full = 1'b1;
    send_pkt(6, 1'b0, {8{$urandom}}, {4{$urandom}});
    toggle_full = 1'b0;
    bus.pkt_fifo_full = 1'b0;
    wait_phv(1);
    checks++; if (mirror_bad != 0) begin errors++; $display("FAIL bp_tready_mirror got %0d bad cycles exp 0", mirror_bad); end
    checks++; if (obs_beat_q.size() != 6) begin errors++; $display("FAIL bp_beats got %0d exp 6", obs_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL bp_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL bp_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  task automatic test_back_to_back();
    logic [2303:0] ep, op;
    beat_t eb, ob;
    send_pkt(8, 1'b0, {8{$urandom}}, {4{$urandom}});
    send_pkt(1, 1'b0, {8{$urandom}}, {4{$urandom}});
    wait_phv(2);
    for (int s = 1; s < 8; s++) begin
      checks++;
      if (obs_phv_q[1][256 + s*256 +: 256] !== 256'd0) begin errors++; $display("FAIL b2b_stale_slot %0d got %h exp 0", s, obs_phv_q[1][256 + s*256 +: 256]); end
    end
    checks++; if (obs_beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL b2b_beats got %0d exp %0d", obs_beat_q.size(), exp_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL b2b_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL b2b_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    checks++; if (bus.pkt_count !== exp_count) begin errors++; $display("FAIL b2b_pkt_count got %0d exp %0d", bus.pkt_count, exp_count); end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  task automatic test_reset_mid();
    logic [2303:0] ep, op;
    beat_t eb, ob;
    for (int i = 0; i < 3; i++) send_beat({8{$urandom}}, 32'hFFFF_FFFF, {4{$urandom}}, 1'b0);
    bus.s_axis_tdata = {8{$urandom}}; bus.s_axis_tvalid = 1'b1; bus.s_axis_tlast = 1'b0;
    areset = 1'b1;
    clk_step();
    checks++; if (rdy_s !== 1'b0 || pktwr_s !== 1'b0) begin errors++; $display("FAIL midreset tready %b pkt_wr %b exp 0 0", rdy_s, pktwr_s); end
    clk_step();
    areset = 1'b0; bus.s_axis_tvalid = 1'b0;
    exp_count = 32'd0;
    clk_step(); clk_step(); clk_step();
    checks++; if (obs_phv_q.size() != 0) begin errors++; $display("FAIL midreset_phv_writes got %0d exp 0", obs_phv_q.size()); end
    checks++; if (bus.pkt_count !== 32'd0) begin errors++; $display("FAIL midreset_pkt_count got %0d exp 0", bus.pkt_count); end
    send_pkt(2, 1'b0, {8{$urandom}}, {4{$urandom}});
    wait_phv(1);
    checks++; if (obs_phv_q[0][147:140] !== 8'd2) begin errors++; $display("FAIL midreset_beat_count got %0d exp 2", obs_phv_q[0][147:140]); end
    checks++; if (obs_beat_q.size() != exp_beat_q.size()) begin errors++; $display("FAIL midreset_beats got %0d exp %0d", obs_beat_q.size(), exp_beat_q.size()); end
    while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
      eb = exp_beat_q.pop_front(); ob = obs_beat_q.pop_front(); checks++;
      if (ob !== eb) begin errors++; $display("FAIL midreset_beat got %h exp %h", ob, eb); end
    end
    while (exp_phv_q.size() > 0 && obs_phv_q.size() > 0) begin
      ep = exp_phv_q.pop_front(); op = obs_phv_q.pop_front();
      for (int w = 0; w < 9; w++) begin
        checks++;
        if (op[w*256 +: 256] !== ep[w*256 +: 256]) begin errors++; $display("FAIL midreset_phv word %0d got %h exp %h", w, op[w*256 +: 256], ep[w*256 +: 256]); end
      end
    end
    checks++; if (bus.pkt_count !== exp_count) begin errors++; $display("FAIL midreset_pkt_count_after got %0d exp %0d", bus.pkt_count, exp_count); end
    exp_beat_q.delete(); obs_beat_q.delete(); exp_phv_q.delete(); obs_phv_q.delete(); obs_phv_cyc.delete();
  endtask

  initial begin
    areset            = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.pkt_fifo_full = 1'b0;
    bus.phv_fifo_full = 1'b0;
    test_reset();
    test_single_beat();
    test_long_pkt();
    test_phv_full();
    test_pkt_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
